uart_rx: RTL and testbench

- 8N1 UART receiver peripheral feeding the SoC bus-side UART register block; consumes the serial line driven by the host or bench (rx pin) and produces bytes for core loads.
- Synchronises the rx line, detects and validates the start bit, samples data bits at mid-bit and checks the stop bit.
- Buffers received bytes in a first-word-fall-through FIFO popped by the bus interface.
- Reports overrun and framing errors as sticky flags.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 27 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK_WAIT
  } uart_rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Bus-side view of the UART receiver: FIFO pop port, occupancy and sticky error flags.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                      rd_en_i;
  logic                      clr_err_i;
  logic [UART_DATA_BITS-1:0] rd_data_o;
  logic                      rx_valid_o;
  logic [CW-1:0]             fifo_count_o;
  logic                      overrun_o;
  logic                      frame_err_o;

  modport master (
    output rd_en_i, clr_err_i,
    input  rd_data_o, rx_valid_o, fifo_count_o, overrun_o, frame_err_o
  );

  modport slave (
    input  rd_en_i, clr_err_i,
    output rd_data_o, rx_valid_o, fifo_count_o, overrun_o, frame_err_o
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible whenever not empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [WIDTH-1:0]             head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is still accepted when the head leaves on the same cycle.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, frames bytes at mid-bit and queues them in a FWFT FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     rx_i,
  uart_rx_if.slave bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] HALF_LIM = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LIM = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]                sync_q, sync_d;
  logic                      rx_s;
  uart_rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;
  logic                      push, frame_set, overrun_set;
  logic                      fifo_full, fifo_empty;
  logic [CW-1:0]             fifo_count;
  logic [UART_DATA_BITS-1:0] fifo_head;

  assign sync_d = {sync_q[0], rx_i};
  assign rx_s   = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b11;
    else         sync_q <= sync_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LIM) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_LIM) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_LIM) begin
          cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = BRK_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // A held-low line must return high before a new start bit is accepted.
      BRK_WAIT: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign overrun_set = push && fifo_full && !bus.rd_en_i;
  assign frame_err_d = frame_set   || (frame_err_q && !bus.clr_err_i);
  assign overrun_d   = overrun_set || (overrun_q && !bus.clr_err_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (bus.rd_en_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign bus.rd_data_o    = fifo_head;
  assign bus.rx_valid_o   = !fifo_empty;
  assign bus.fifo_count_o = fifo_count;
  assign bus.overrun_o    = overrun_q;
  assign bus.frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames in, bytes compared against a queue model.
module tb_uart_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  // Edges from driving the start bit to the stop-sample edge (includes synchroniser delay).
  localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] mq [$];
  logic       m_overrun = 1'b0;
  logic       m_frame = 1'b0;

  uart_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rx_i   (rx),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else                   m_overrun = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 rx = f[i];
      repeat (CPB - 1) @(posedge clk);
    end
    repeat (CPB) @(posedge clk);
    #1;
    if (stop_ok) model_push(b);
    else         m_frame = 1'b1;
  endtask

  task automatic pop_byte(input string name);
    checks++;
    if (bus.rx_valid_o !== (mq.size() != 0)) begin
      failures++;
      $display("[TB] FAIL %s valid got=%b exp=%b", name, bus.rx_valid_o, mq.size() != 0);
    end
    if (mq.size() != 0) begin
      checks++;
      if (bus.rd_data_o !== mq[0]) begin
        failures++;
        $display("[TB] FAIL %s data got=%h exp=%h", name, bus.rd_data_o, mq[0]);
      end
    end
    bus.rd_en_i = 1'b1;
    @(posedge clk); #1 bus.rd_en_i = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic clear_errors();
    @(posedge clk); #1 bus.clr_err_i = 1'b1;
    @(posedge clk); #1 bus.clr_err_i = 1'b0;
    m_overrun = 1'b0;
    m_frame   = 1'b0;
  endtask

  task automatic test_reset();
    bus.rd_en_i = 1'b0; bus.clr_err_i = 1'b0; rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.rx_valid_o, bus.fifo_count_o, bus.overrun_o, bus.frame_err_o, bus.rd_data_o} !== '0) begin
      failures++;
      $display("[TB] FAIL reset outputs got=%b/%0d/%b/%b/%h exp=0", bus.rx_valid_o,
               bus.fifo_count_o, bus.overrun_o, bus.frame_err_o, bus.rd_data_o);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    send_frame(8'h41, 1'b1);
    checks++;
    if (bus.fifo_count_o !== CW'(1)) begin
      failures++; $display("[TB] FAIL b2b count1 got=%0d exp=1", bus.fifo_count_o);
    end
    send_frame(8'h42, 1'b1);
    checks++;
    if (bus.fifo_count_o !== CW'(2)) begin
      failures++; $display("[TB] FAIL b2b count2 got=%0d exp=2", bus.fifo_count_o);
    end
    pop_byte("b2b pop41");
    pop_byte("b2b pop42");
    checks++;
    if ({bus.rx_valid_o, bus.overrun_o, bus.frame_err_o} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL b2b final valid/ovr/ferr got=%b%b%b exp=000",
               bus.rx_valid_o, bus.overrun_o, bus.frame_err_o);
    end
  endtask

  task automatic test_glitch();
    @(posedge clk); #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    checks++;
    if ({bus.fifo_count_o, bus.frame_err_o} !== {CW'(0), 1'b0}) begin
      failures++;
      $display("[TB] FAIL glitch count/ferr got=%0d/%b exp=0/0", bus.fifo_count_o, bus.frame_err_o);
    end
  endtask

  task automatic test_frame_error();
    send_frame(8'h55, 1'b0);
    repeat (40) @(posedge clk);
    #1 rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (bus.frame_err_o !== m_frame) begin
      failures++; $display("[TB] FAIL ferr set got=%b exp=%b", bus.frame_err_o, m_frame);
    end
    checks++;
    if (bus.fifo_count_o !== CW'(0)) begin
      failures++; $display("[TB] FAIL ferr discard count got=%0d exp=0", bus.fifo_count_o);
    end
    send_frame(8'hA3, 1'b1);
    checks++;
    if (bus.fifo_count_o !== CW'(mq.size())) begin
      failures++; $display("[TB] FAIL ferr A3 count got=%0d exp=%0d", bus.fifo_count_o, mq.size());
    end
    pop_byte("ferr popA3");
    clear_errors();
    checks++;
    if (bus.frame_err_o !== 1'b0) begin
      failures++; $display("[TB] FAIL ferr clear got=%b exp=0", bus.frame_err_o);
    end
  endtask

  task automatic test_pop_empty();
    pop_byte("empty pop");
    checks++;
    if ({bus.fifo_count_o, bus.overrun_o, bus.rd_data_o} !== {CW'(0), 1'b0, 8'h00}) begin
      failures++;
      $display("[TB] FAIL empty pop state got=%0d/%b/%h exp=0/0/00",
               bus.fifo_count_o, bus.overrun_o, bus.rd_data_o);
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    checks++;
    if (bus.fifo_count_o !== CW'(DEPTH)) begin
      failures++; $display("[TB] FAIL ovr count got=%0d exp=%0d", bus.fifo_count_o, DEPTH);
    end
    checks++;
    if (bus.overrun_o !== m_overrun) begin
      failures++; $display("[TB] FAIL ovr flag got=%b exp=%b", bus.overrun_o, m_overrun);
    end
    for (int i = 0; i < DEPTH; i++) pop_byte("ovr drain");
    clear_errors();
    checks++;
    if (bus.overrun_o !== 1'b0) begin
      failures++; $display("[TB] FAIL ovr clear got=%b exp=0", bus.overrun_o);
    end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    checks++;
    if (bus.rd_data_o !== mq[0]) begin
      failures++; $display("[TB] FAIL fullpop head got=%h exp=%h", bus.rd_data_o, mq[0]);
    end
    fork
      send_frame(8'h99, 1'b1);
      begin
        @(posedge clk);
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1 bus.rd_en_i = 1'b1;
        @(posedge clk); #1 bus.rd_en_i = 1'b0;
        void'(mq.pop_front());
      end
    join
    checks++;
    if ({bus.overrun_o, bus.fifo_count_o} !== {1'b0, CW'(DEPTH)}) begin
      failures++;
      $display("[TB] FAIL fullpop ovr/count got=%b/%0d exp=0/%0d", bus.overrun_o, bus.fifo_count_o, DEPTH);
    end
    checks++;
    if (mq[DEPTH-1] !== 8'h99) begin
      failures++; $display("[TB] FAIL fullpop model tail got=%h exp=99", mq[DEPTH-1]);
    end
    for (int i = 0; i < DEPTH; i++) pop_byte("fullpop drain");
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h11, 1'b1);
    @(posedge clk); #1 rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rx_valid_o, bus.fifo_count_o, bus.overrun_o, bus.frame_err_o, bus.rd_data_o} !== '0) begin
      failures++;
      $display("[TB] FAIL midreset outputs got=%b/%0d/%b/%b/%h exp=0", bus.rx_valid_o,
               bus.fifo_count_o, bus.overrun_o, bus.frame_err_o, bus.rd_data_o);
    end
    rx = 1'b1;
    mq.delete();
    m_overrun = 1'b0;
    m_frame   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_frame(8'h3C, 1'b1);
    checks++;
    if ({bus.fifo_count_o, bus.frame_err_o} !== {CW'(1), 1'b0}) begin
      failures++;
      $display("[TB] FAIL midreset after count/ferr got=%0d/%b exp=1/0", bus.fifo_count_o, bus.frame_err_o);
    end
    pop_byte("midreset pop3C");
    checks++;
    if (bus.rx_valid_o !== 1'b0) begin
      failures++; $display("[TB] FAIL midreset empty got=%b exp=0", bus.rx_valid_o);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1);
      checks++;
      if ({bus.fifo_count_o, bus.overrun_o, bus.frame_err_o} !== {CW'(mq.size()), m_overrun, m_frame}) begin
        failures++;
        $display("[TB] FAIL rand%0d count/ovr/ferr got=%0d/%b/%b exp=%0d/%b/%b", n, bus.fifo_count_o,
                 bus.overrun_o, bus.frame_err_o, mq.size(), m_overrun, m_frame);
      end
      if ($urandom_range(0, 2) == 0) pop_byte("rand pop");
      if ($urandom_range(0, 5) == 0) clear_errors();
    end
    while (mq.size() != 0) pop_byte("rand drain");
    checks++;
    if (bus.rx_valid_o !== 1'b0) begin
      failures++; $display("[TB] FAIL rand final valid got=%b exp=0", bus.rx_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_pop_empty();
    test_overrun();
    test_full_pop();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
